serial_tx_fifo: RTL and testbench
=================================

Name: serial_tx_fifo

Overview:
Byte buffer and send sequencer directly upstream of the serial transmitter (`serial_t`). Producers push bytes at full clock rate. The block stores them in a synchronous FIFO and hands them one at a time to the transmitter over its data/send/busy handshake. This lets software or other logic queue a burst without polling transmitter busy.

Parameters:
DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
wr_data  in  8  byte to queue.
wr_en  in  1  push request; accepted iff full=0 in the same cycle.
full  out  1  registered; count==DEPTH.
empty  out  1  registered; count==0.
count  out  ADDR_W+1  bytes currently stored (excludes the byte held in tx_data).
overflow  out  1  sticky; set by wr_en while full; cleared only by reset.
tx_data  out  8  byte presented to the transmitter; registered, stable while tx_send=1.
tx_send  out  1  send request to the transmitter.
tx_busy  in  1  transmitter busy; rises the cycle after it samples send, falls when the stop bit completes.

Behaviour:
- Reset (rst=0 at an edge):
  - read/write pointers=0, count=0, empty=1, full=0, overflow=0.
  - tx_data=8'h00, tx_send=0, FSM=IDLE.
  - FIFO contents need no clearing.
- Push: when wr_en=1 and full=0, store wr_data at wr_ptr; wr_ptr wraps modulo DEPTH.
- Push while full: data is dropped, pointers unchanged, overflow<=1.
- Pop: occurs only on the FSM IDLE->SEND transition. Reads mem[rd_ptr] into tx_data; rd_ptr wraps modulo DEPTH.
- count arithmetic:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
  - Push at full is rejected even if a pop happens in the same cycle; full is the registered value.
  - Pop when empty is impossible because the FSM gates it.
- FSM states: IDLE, SEND, DRAIN (2-bit encoding).
  - IDLE: tx_send=0. If empty=0 and tx_busy=0: pop, go to SEND. Otherwise stay.
  - SEND: tx_send=1 (decoded from state), tx_data held. If tx_busy=1, go to DRAIN. Otherwise stay, keeping send asserted until the transmitter takes the byte.
  - DRAIN: tx_send=0. If tx_busy=0, go to IDLE.
  - Illegal state: go to IDLE.
- Latency from a push into an empty FIFO with transmitter idle:
  - wr_en sampled at edge k: count=1, empty=0 after edge k.
  - Pop at edge k+1; tx_send high during cycle k+1..k+2.
  - Transmitter sees send at edge k+2; tx_busy high after k+2; FSM reaches DRAIN at edge k+3.
- Back-to-back bytes: the next pop occurs at the first edge where FSM=IDLE and tx_busy=0. That gives at most 2 idle cycles between frames beyond the transmitter's own turnaround.
- If tx_busy is already high in IDLE (transmitter blocked), no pop occurs; bytes stay queued.
- Reset mid-frame: the FIFO and FSM clear, and any byte in tx_data is discarded. The transmitter completes its current frame under its own reset domain.
- No combinational path from wr_en to full/empty/count. tx_send depends on state only.

Decomposition:
- Shared package `serial_pkg`:
  - FSM state localparams (ST_IDLE, ST_SEND, ST_DRAIN).
  - BYTE_W=8.
  - Default DEPTH.
- One sub-module, `sync_fifo`: parameterised DEPTH/width, single-clock, registered full/empty/count, push/pop ports, overflow flag.
- The top level holds the FSM and the tx_data register.

Test Plan:
1. Reset: drive rst=0 for 2 cycles with wr_en=1 -> empty=1, full=0, count=0, overflow=0, tx_send=0, tx_data=8'h00. No write is accepted.
2. Single byte: push 8'hA5 with tx_busy=0. Model busy rising 1 cycle after send and staying high 10 cycles -> tx_send high exactly from cycle k+1 to k+2 with tx_data=8'hA5, then count=0 and empty=1.
3. Burst: push 8'h01..8'h10 on consecutive cycles (DEPTH=16) with the transmitter model busy -> full=1 after 16 pushes, and a 17th push sets overflow=1. Bytes are sent in order 01..10, each tx_send held until tx_busy=1.
4. Simultaneous push/pop: count=3, push at the cycle the FSM pops -> count stays 3 and pointers wrap correctly across index DEPTH-1->0.
5. Blocked transmitter: hold tx_busy=1 for 50 cycles with 4 bytes queued -> no pop, count=4. Release -> 4 frames issued in order.
6. Reset mid-frame: assert rst=0 while in SEND with 5 bytes queued -> next cycle tx_send=0, count=0. The queued bytes are never sent.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit path.
package serial_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

endpackage

// File: rtl/serial_tx_fifo_if.sv
// Producer-side push port and transmitter-side data/send/busy handshake.
interface serial_tx_fifo_if
  import serial_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [BYTE_W-1:0] wr_data;
  logic              wr_en;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_send;
  logic              tx_busy;

  // slave: the buffer itself; master: producer plus transmitter side
  modport slave (
    input  wr_data, wr_en, tx_busy,
    output full, empty, count, overflow, tx_data, tx_send
  );

  modport master (
    output wr_data, wr_en, tx_busy,
    input  full, empty, count, overflow, tx_data, tx_send
  );

endinterface

// File: rtl/serial_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count and a sticky overflow flag.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_c,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              push_ok, pop_ok;

  // Gating uses the registered flags, so a pop never frees room for a same-cycle push.
  always_comb begin
    push_ok    = push_i && !full_q;
    pop_ok     = pop_i && !empty_q;
    wr_ptr_d   = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_ok ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    full_d     = (count_d == CNT_W'(DEPTH));
    empty_d    = (count_d == '0);
    overflow_d = overflow_q || (push_i && full_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_c = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/serial_tx_fifo.sv
// Byte queue feeding the serial transmitter one byte at a time over send/busy.
module serial_tx_fifo
  import serial_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  serial_tx_fifo_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  tx_state_e         state_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic              tx_send_q;
  logic              pop_c;
  logic [BYTE_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W:0]   fifo_count;
  logic              fifo_overflow;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus.wr_en),
    .push_data_i (bus.wr_data),
    .pop_i       (pop_c),
    .pop_data_c  (fifo_rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .overflow_o  (fifo_overflow)
  );

  // Pop only when idle, data is queued and the transmitter is free.
  assign pop_c = (state_q == ST_IDLE) && !fifo_empty && !bus.tx_busy;

  // tx_send_q mirrors state_q == ST_SEND, kept as its own flop so the output is registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_c) begin
            state_q   <= ST_SEND;
            tx_data_q <= fifo_rd_data;
            tx_send_q <= 1'b1;
          end
        end
        ST_SEND: begin
          if (bus.tx_busy) begin
            state_q   <= ST_DRAIN;
            tx_send_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!bus.tx_busy) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          tx_send_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_send  = tx_send_q;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.count    = fifo_count;
  assign bus.overflow = fifo_overflow;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed testbench for serial_tx_fifo with a simple transmitter busy model.
module tb_serial_tx_fifo;
  import serial_pkg::*;

  localparam int FRAME = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_tx_fifo_if bus ();

  serial_tx_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic       hold_busy  = 1'b0;
  logic       model_on   = 1'b1;
  logic       model_busy = 1'b0;
  int         busy_cnt   = 0;
  logic [7:0] sent[$];

  assign bus.tx_busy = hold_busy | model_busy;

  // Transmitter: samples send, raises busy next cycle for FRAME cycles.
  always @(posedge clk) begin
    if (model_busy) begin
      if (busy_cnt <= 1) begin
        model_busy <= 1'b0;
        busy_cnt   <= 0;
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end else if (model_on && bus.tx_send && !hold_busy) begin
      model_busy <= 1'b1;
      busy_cnt   <= FRAME;
      sent.push_back(bus.tx_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_sent(input int target, input int budget);
    int n;
    n = 0;
    while (sent.size() < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sent.size() < target) begin
      errors++;
      $display("FAIL wait_sent: got %0d frames, required %0d", sent.size(), target);
    end
    n = 0;
    while (bus.tx_busy && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h55;
    tick();
    tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b required 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", bus.full); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", bus.overflow); end
    checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL reset_send: got %b required 0", bus.tx_send); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", bus.tx_data); end
    bus.wr_en = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_nowrite: got %0d required 0", bus.count); end
  endtask

  task automatic test_single();
    int base;
    base = sent.size();
    push(8'hA5);
    checks++; if (bus.count !== 5'd1 || bus.empty !== 1'b0) begin errors++; $display("FAIL single_k_count: got %0d/%b required 1/0", bus.count, bus.empty); end
    checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL single_k_send: got %b required 0", bus.tx_send); end
    tick();
    checks++; if (bus.tx_send !== 1'b1 || bus.tx_data !== 8'hA5) begin errors++; $display("FAIL single_k1: got send=%b data=%h required 1/a5", bus.tx_send, bus.tx_data); end
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL single_k1_count: got %0d/%b required 0/1", bus.count, bus.empty); end
    tick();
    checks++; if (bus.tx_send !== 1'b1 || bus.tx_busy !== 1'b1) begin errors++; $display("FAIL single_k2: got send=%b busy=%b required 1/1", bus.tx_send, bus.tx_busy); end
    tick();
    checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL single_k3_send: got %b required 0", bus.tx_send); end
    wait_sent(base + 1, 100);
    checks++; if (sent.size() != base + 1 || sent[base] !== 8'hA5) begin errors++; $display("FAIL single_frame: got %0d frames required %0d with a5", sent.size(), base + 1); end
  endtask

  task automatic test_burst();
    int base;
    base = sent.size();
    hold_busy = 1'b1;
    for (int i = 1; i <= 16; i++) push(8'(i));
    checks++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin errors++; $display("FAIL burst_full: got full=%b count=%0d required 1/16", bus.full, bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL burst_no_ovf: got %b required 0", bus.overflow); end
    push(8'h11);
    checks++; if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin errors++; $display("FAIL burst_ovf: got ovf=%b count=%0d required 1/16", bus.overflow, bus.count); end
    hold_busy = 1'b0;
    wait_sent(base + 16, 800);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (sent.size() <= base + i || sent[base + i] !== 8'(i + 1)) begin
        errors++;
        $display("FAIL burst_order[%0d]: got %h required %h", i, (sent.size() > base + i) ? sent[base + i] : 8'hxx, 8'(i + 1));
      end
    end
    checks++; if (sent.size() != base + 16) begin errors++; $display("FAIL burst_count: got %0d frames required %0d", sent.size() - base, 16); end
    checks++; if (bus.overflow !== 1'b1 || bus.empty !== 1'b1) begin errors++; $display("FAIL burst_sticky: got ovf=%b empty=%b required 1/1", bus.overflow, bus.empty); end
  endtask

  task automatic test_simultaneous();
    int base;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL sim_ovf_clear: got %b required 0", bus.overflow); end
    hold_busy = 1'b1;
    for (int i = 0; i < 13; i++) push(8'h20 + 8'(i));
    hold_busy = 1'b0;
    wait_sent(sent.size() + 13, 600);
    base = sent.size();
    hold_busy = 1'b1;
    push(8'h40);
    push(8'h41);
    push(8'h42);
    checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL sim_pre_count: got %0d required 3", bus.count); end
    hold_busy = 1'b0;
    push(8'h43);
    checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL sim_count: got %0d required 3", bus.count); end
    checks++; if (bus.tx_send !== 1'b1 || bus.tx_data !== 8'h40) begin errors++; $display("FAIL sim_pop: got send=%b data=%h required 1/40", bus.tx_send, bus.tx_data); end
    wait_sent(base + 4, 200);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sent.size() <= base + i || sent[base + i] !== 8'h40 + 8'(i)) begin
        errors++;
        $display("FAIL sim_order[%0d]: got %h required %h", i, (sent.size() > base + i) ? sent[base + i] : 8'hxx, 8'h40 + 8'(i));
      end
    end
  endtask

  task automatic test_blocked();
    int base;
    base = sent.size();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
    repeat (50) tick();
    checks++; if (bus.count !== 5'd4 || bus.tx_send !== 1'b0) begin errors++; $display("FAIL blocked_hold: got count=%0d send=%b required 4/0", bus.count, bus.tx_send); end
    checks++; if (sent.size() != base) begin errors++; $display("FAIL blocked_nosend: got %0d frames required 0", sent.size() - base); end
    hold_busy = 1'b0;
    wait_sent(base + 4, 200);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sent.size() <= base + i || sent[base + i] !== 8'h50 + 8'(i)) begin
        errors++;
        $display("FAIL blocked_order[%0d]: got %h required %h", i, (sent.size() > base + i) ? sent[base + i] : 8'hxx, 8'h50 + 8'(i));
      end
    end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL blocked_drain: got %0d required 0", bus.count); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = sent.size();
    model_on = 1'b0;
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    hold_busy = 1'b0;
    tick();
    checks++; if (bus.tx_send !== 1'b1 || bus.count !== 5'd5 || bus.tx_data !== 8'h60) begin errors++; $display("FAIL mid_send: got send=%b count=%0d data=%h required 1/5/60", bus.tx_send, bus.count, bus.tx_data); end
    repeat (3) tick();
    checks++; if (bus.tx_send !== 1'b1) begin errors++; $display("FAIL mid_hold_send: got %b required 1", bus.tx_send); end
    rst = 1'b0;
    tick();
    checks++; if (bus.tx_send !== 1'b0 || bus.count !== 5'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL mid_reset: got send=%b count=%0d empty=%b required 0/0/1", bus.tx_send, bus.count, bus.empty); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %h required 00", bus.tx_data); end
    rst = 1'b1;
    model_on = 1'b1;
    repeat (40) tick();
    checks++; if (sent.size() != base || bus.count !== 5'd0) begin errors++; $display("FAIL mid_discard: got %0d frames count=%0d required 0/0", sent.size() - base, bus.count); end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    test_reset();
    test_single();
    test_burst();
    test_simultaneous();
    test_blocked();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
